// File: rtl/demux_ctrl_if.sv
// demux_ctrl_if: upstream handshake, lane backpressure, lane outputs and
// debug state of the two-lane alternating demultiplexer.
// Handshake: a word moves when valid_in && ready_in are both high at a
// rising clk edge; upstream keeps data_in stable while valid_in waits for
// ready_in; each lane output is a one-cycle valid_outx pulse per transfer
// with no downstream ready (lanes throttle through pause0/pause1 instead).
interface demux_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_in;
    logic              pause0;
    logic              pause1;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out0;
    logic              valid_out1;
    logic [1:0]        state_out;

    // Block side: consumes upstream words and lane pauses, drives lanes.
    modport slave (
        input  data_in,
        input  valid_in,
        output ready_in,
        input  pause0,
        input  pause1,
        output data_out0,
        output data_out1,
        output valid_out0,
        output valid_out1,
        output state_out
    );

    // Environment side: upstream source plus both downstream lanes.
    modport master (
        output data_in,
        output valid_in,
        input  ready_in,
        output pause0,
        output pause1,
        input  data_out0,
        input  data_out1,
        input  valid_out0,
        input  valid_out1,
        input  state_out
    );
endinterface

// File: rtl/demux_ctrl.sv
// demux_ctrl: routes upstream words alternately to lane 0 and lane 1 with a
// registered one-cycle output latency. A paused lane is skipped when the
// other lane can take data; with both lanes paused everything holds.
// Optional build macro DEMUX_CTRL_STATS_EN adds saturating per-lane
// transfer counters on ports count0/count1.
module demux_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    demux_ctrl_if.slave       bus
`ifdef DEMUX_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1
`endif
);

    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_LANE0 = 2'b01;
    localparam logic [1:0] ST_LANE1 = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_out0_q, data_out0_d;
    logic [DATA_W-1:0] data_out1_q, data_out1_d;
    logic              valid_out0_q, valid_out0_d;
    logic              valid_out1_q, valid_out1_d;
    logic              ready_c;
    logic              xfer0_c;
    logic              xfer1_c;

    // Ready depends only on the current lane and its pause, so a pause
    // change reaches ready_in in the same cycle.
    always_comb begin
        ready_c = 1'b0;
        case (state_q)
            ST_LANE0: ready_c = !bus.pause0;
            ST_LANE1: ready_c = !bus.pause1;
            default:  ready_c = 1'b0;
        endcase
        xfer0_c = bus.valid_in && ready_c && (state_q == ST_LANE0);
        xfer1_c = bus.valid_in && ready_c && (state_q == ST_LANE1);
    end

    // Lane sequencing: alternate on transfers, skip a paused lane when the
    // other one is free, hold when idle or when both lanes are paused.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_LANE0;
            ST_LANE0: begin
                if (xfer0_c) begin
                    state_d = ST_LANE1;
                end else if (bus.pause0 && !bus.pause1) begin
                    state_d = ST_LANE1;
                end
            end
            ST_LANE1: begin
                if (xfer1_c) begin
                    state_d = ST_LANE0;
                end else if (bus.pause1 && !bus.pause0) begin
                    state_d = ST_LANE0;
                end
            end
            default:  state_d = ST_INIT;
        endcase
    end

    // Lane output registers: capture on a transfer, otherwise keep the last
    // word; valid is a single-cycle pulse per transfer.
    always_comb begin
        data_out0_d  = xfer0_c ? bus.data_in : data_out0_q;
        data_out1_d  = xfer1_c ? bus.data_in : data_out1_q;
        valid_out0_d = xfer0_c;
        valid_out1_d = xfer1_c;
    end

    // State and lane registers; reset clears everything at once, which also
    // drops any word accepted in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            data_out0_q  <= '0;
            data_out1_q  <= '0;
            valid_out0_q <= 1'b0;
            valid_out1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out0_q  <= data_out0_d;
            data_out1_q  <= data_out1_d;
            valid_out0_q <= valid_out0_d;
            valid_out1_q <= valid_out1_d;
        end
    end

    assign bus.ready_in   = ready_c;
    assign bus.data_out0  = data_out0_q;
    assign bus.data_out1  = data_out1_q;
    assign bus.valid_out0 = valid_out0_q;
    assign bus.valid_out1 = valid_out1_q;
    assign bus.state_out  = state_q;

`ifdef DEMUX_CTRL_STATS_EN
    logic [CNT_W-1:0] count0_q, count0_d;
    logic [CNT_W-1:0] count1_q, count1_d;

    // Per-lane transfer counters that stick at all-ones instead of wrapping.
    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (xfer0_c && (count0_q != '1)) begin
            count0_d = count0_q + 1'b1;
        end
        if (xfer1_c && (count1_q != '1)) begin
            count1_d = count1_q + 1'b1;
        end
    end

    // Counters clear only on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign count0 = count0_q;
    assign count1 = count1_q;
`else
    // Counter width has no hardware in this build; keep it referenced.
    localparam logic [31:0] CNT_W_L = CNT_W;
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W_L;
`endif

endmodule

// File: tb/tb_demux_ctrl.sv
// tb_demux_ctrl: directed vector table, hand-written reset/stats sequences
// and a randomized run against a lane-alternation reference model.
module tb_demux_ctrl;

    localparam int DATA_W = 8;
`ifdef DEMUX_CTRL_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 8;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    demux_ctrl_if #(.DATA_W(DATA_W)) bus ();

`ifdef DEMUX_CTRL_STATS_EN
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;
`endif

    demux_ctrl #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DEMUX_CTRL_STATS_EN
        ,
        .count0(count0),
        .count1(count1)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which lane is next, whether the first post-reset
    // edge has passed, what each lane shows, and how many words each took.
    bit          m_started;
    int          m_lane;
    logic [7:0]  m_dout [2];
    bit          m_vout [2];
    int          m_cnt  [2];
    logic [8:0]  exp_q[$];   // {lane, data} of accepted words, in order

    task automatic model_reset();
        m_started = 1'b0;
        m_lane    = 0;
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = '0;
            m_vout[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        exp_q.delete();
    endtask

    function automatic bit model_ready(input bit p0, input bit p1);
        bit p_cur;
        p_cur = (m_lane == 0) ? p0 : p1;
        return m_started && !p_cur;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit v, input logic [7:0] d, input bit p0, input bit p1);
        bit p[2];
        p[0] = p0;
        p[1] = p1;
        m_vout[0] = 1'b0;
        m_vout[1] = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
            m_lane    = 0;
        end else if (v && !p[m_lane]) begin
            m_dout[m_lane] = d;
            m_vout[m_lane] = 1'b1;
            if (m_cnt[m_lane] < (1 << CNT_W) - 1) m_cnt[m_lane]++;
            exp_q.push_back({m_lane[0], d});
            m_lane = 1 - m_lane;
        end else if (p[m_lane] && !p[1 - m_lane]) begin
            m_lane = 1 - m_lane;
        end
    endtask

    function automatic logic [1:0] model_state();
        if (!m_started) return 2'b00;
        return (m_lane == 0) ? 2'b01 : 2'b10;
    endfunction

    // Driver tasks
    task automatic drive(input bit v, input logic [7:0] d, input bit p0, input bit p1);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.pause0   = p0;
        bus.pause1   = p1;
    endtask

    task automatic check_onehot();
        check("onehot_valid", 32'(bus.valid_out0 && bus.valid_out1), 32'd0);
    endtask

    // Compare registered outputs to the model and drain the scoreboard.
    task automatic check_model_outputs();
        logic [8:0] got;
        check("valid_out0", 32'(bus.valid_out0), 32'(m_vout[0]));
        check("valid_out1", 32'(bus.valid_out1), 32'(m_vout[1]));
        check("data_out0", 32'(bus.data_out0), 32'(m_dout[0]));
        check("data_out1", 32'(bus.data_out1), 32'(m_dout[1]));
        check("state_out", 32'(bus.state_out), 32'(model_state()));
        check_onehot();
        if (bus.valid_out0 || bus.valid_out1) begin
            got = {bus.valid_out1, bus.valid_out1 ? bus.data_out1 : bus.data_out0};
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(got), 32'h1ff);
            end else begin
                check("sb_word", 32'(got), 32'(exp_q.pop_front()));
            end
        end
`ifdef DEMUX_CTRL_STATS_EN
        check("count0", 32'(count0), 32'(m_cnt[0]));
        check("count1", 32'(count1), 32'(m_cnt[1]));
`endif
    endtask

    // One modelled cycle: drive, check combinational ready, clock, compare.
    task automatic model_cycle(input bit v, input logic [7:0] d, input bit p0, input bit p1);
        drive(v, d, p0, p1);
        #1;
        check("ready_in", 32'(bus.ready_in), 32'(model_ready(p0, p1)));
        model_edge(v, d, p0, p1);
        @(posedge clk);
        #1;
        check_model_outputs();
    endtask

    // Assert reset away from the edge, check the immediate clear, release
    // one edge later.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_state", 32'(bus.state_out), 32'd0);
        check("rst_ready", 32'(bus.ready_in), 32'd0);
        check("rst_valid0", 32'(bus.valid_out0), 32'd0);
        check("rst_valid1", 32'(bus.valid_out1), 32'd0);
        check("rst_data0", 32'(bus.data_out0), 32'd0);
        check("rst_data1", 32'(bus.data_out1), 32'd0);
`ifdef DEMUX_CTRL_STATS_EN
        check("rst_count0", 32'(count0), 32'd0);
        check("rst_count1", 32'(count1), 32'd0);
`endif
        @(posedge clk);
        #1;
        check("rst_hold_valid0", 32'(bus.valid_out0), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       p0;
        logic       p1;
        logic       e_rdy;
        logic [1:0] e_st;
        logic       e_v0;
        logic       e_v1;
        logic [7:0] e_d0;
        logic [7:0] e_d1;
    } vec_t;

    vec_t tbl [16];

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        do_reset();

        // Vector table, applied from INIT right after reset release.
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'hA1, 8'h00};
        tbl[2]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'hA1, 8'hB2};
        tbl[3]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'hC3, 8'hB2};
        tbl[4]  = '{1'b1, 8'hD4, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'hC3, 8'hD4};
        tbl[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 8'hC3, 8'hD4};
        tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'hC3, 8'h55};
        for (int i = 7; i < 12; i++) begin
            tbl[i] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'hC3, 8'h55};
        end
        tbl[12] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h66, 8'h55};
        tbl[13] = '{1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h66, 8'h55};
        tbl[14] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h66, 8'h55};
        tbl[15] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h88, 8'h55};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].p0, tbl[i].p1);
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(bus.ready_in), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_state", i), 32'(bus.state_out), 32'(tbl[i].e_st));
            check($sformatf("tbl%0d_v0", i), 32'(bus.valid_out0), 32'(tbl[i].e_v0));
            check($sformatf("tbl%0d_v1", i), 32'(bus.valid_out1), 32'(tbl[i].e_v1));
            check($sformatf("tbl%0d_d0", i), 32'(bus.data_out0), 32'(tbl[i].e_d0));
            check($sformatf("tbl%0d_d1", i), 32'(bus.data_out1), 32'(tbl[i].e_d1));
            check_onehot();
        end

        // Reset while 8'h7E is being offered to lane 0: the word is dropped.
        do_reset();
        model_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h7E, 1'b0, 1'b0);
        #1;
        check("inflight_ready", 32'(bus.ready_in), 32'd1);
        do_reset();
        check("inflight_data0", 32'(bus.data_out0), 32'd0);

        // Reset right after 8'h7E was taken: its valid pulse vanishes at once.
        model_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        model_cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("post_accept_valid0", 32'(bus.valid_out0), 32'd0);
        check("post_accept_data0", 32'(bus.data_out0), 32'd0);
        check("post_accept_state", 32'(bus.state_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

`ifdef DEMUX_CTRL_STATS_EN
        // 40 back-to-back words give 20 per lane; 4-bit counters stick at F.
        model_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            model_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        end
        check("sat_count0", 32'(count0), 32'hF);
        check("sat_count1", 32'(count1), 32'hF);
        do_reset();
`endif

        // Randomized traffic with occasional pauses and rare resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                model_cycle(1'($urandom_range(0, 3) != 0),
                            8'($urandom),
                            1'($urandom_range(0, 3) == 0),
                            1'($urandom_range(0, 3) == 0));
            end
        end

        // Drain: the last accepted word has already been compared.
        model_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
